// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared constants and types for the PC sequencer slice:
//                MIPS opcode/function codes, sequencer FSM encoding and
//                default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
   localparam logic [3:0]  EXEC_STATE_DEFAULT   = 4'b0010;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      ARMED  = 2'd1,
      DELAY  = 2'd2
   } pcseq_state_t;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/branch_target_calc.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_calc
//  Description : Combinational branch/jump target selection from the PC of
//                the branch instruction and its encoding fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_calc
   import pc_seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [5:0]  opcode,
   input  logic [5:0]  fn,
   input  logic [25:0] instr_index,
   input  logic [31:0] rs_data,
   output logic [31:0] target
);

   logic [31:0] pc4;
   logic [15:0] imm;

   assign pc4 = pc + 32'd4;
   assign imm = instr_index[15:0];

   // Pick the target: absolute jump, register jump, or PC-relative branch
   always_comb begin
      target = pc4 + {{14{imm[15]}}, imm, 2'b00};
      if (opcode == OP_J || opcode == OP_JAL) begin
         target = {pc4[31:28], instr_index, 2'b00};
      end else if (opcode == OP_SPECIAL && (fn == FN_JR || fn == FN_JALR)) begin
         // Register target is taken verbatim; misalignment is left to fetch
         target = rs_data;
      end
   end

endmodule : branch_target_calc
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Owns the program counter of the multicycle MIPS core.
//                Latches taken branch/jump targets and applies them after
//                the architectural delay slot; provides link address and a
//                halt indication when execution reaches address 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter logic [3:0]  EXEC_STATE   = EXEC_STATE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  state,
   input  logic        instr_done,
   input  logic        stall,
   input  logic        JumpIN,
   input  logic        Jump_EN,
   input  logic [5:0]  opcode,
   input  logic [5:0]  fn,
   input  logic [25:0] instr_index,
   input  logic [31:0] rs_data,
   output logic [31:0] pc,
   output logic [31:0] link_addr,
   output logic        delay_slot,
   output logic        active
);

   pcseq_state_t fsm_q, fsm_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  target_q, target_d;
   logic         active_q, active_d;
   logic         delay_slot_q, delay_slot_d;

   logic [31:0]  branch_target;
   logic [31:0]  pc4;
   logic         taken;
   logic         at_zero;

   branch_target_calc u_target (
      .pc          (pc_q),
      .opcode      (opcode),
      .fn          (fn),
      .instr_index (instr_index),
      .rs_data     (rs_data),
      .target      (branch_target)
   );

   assign pc4     = pc_q + 32'd4;
   assign taken   = (state == EXEC_STATE) && Jump_EN && JumpIN;
   assign at_zero = (pc_q == 32'd0);

   // Next-state logic: FSM, PC advance, target latch and halt detection
   always_comb begin
      fsm_d    = fsm_q;
      pc_d     = pc_q;
      target_d = target_q;
      active_d = active_q;
      if (!stall) begin
         // PC landed on 0 last edge: drop active now, and freeze from here on
         if (active_q && at_zero) begin
            active_d = 1'b0;
         end
         if (active_q && !at_zero) begin
            unique case (fsm_q)
               NORMAL: begin
                  if (taken) begin
                     target_d = branch_target;
                     if (instr_done) begin
                        pc_d  = pc4;
                        fsm_d = DELAY;
                     end else begin
                        fsm_d = ARMED;
                     end
                  end else if (instr_done) begin
                     pc_d = pc4;
                  end
               end
               ARMED: begin
                  if (instr_done) begin
                     pc_d  = pc4;
                     fsm_d = DELAY;
                  end
               end
               DELAY: begin
                  // A branch sitting in the delay slot is dropped
                  if (instr_done) begin
                     pc_d  = target_q;
                     fsm_d = NORMAL;
                  end
               end
               default: fsm_d = NORMAL;
            endcase
         end
      end
      delay_slot_d = (fsm_d == DELAY);
   end

   // State registers; stall is already folded into the *_d values
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q        <= NORMAL;
         pc_q         <= RESET_VECTOR;
         target_q     <= 32'd0;
         active_q     <= 1'b1;
         delay_slot_q <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         pc_q         <= pc_d;
         target_q     <= target_d;
         active_q     <= active_d;
         delay_slot_q <= delay_slot_d;
      end
   end

   assign pc         = pc_q;
   assign link_addr  = pc_q + 32'd8;
   assign delay_slot = delay_slot_q;
   assign active     = active_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer. Each step
//                pushes its expected post-edge state to a scoreboard queue,
//                clocks the DUT, then pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam logic [31:0] RV      = 32'hBFC0_0000;
   localparam logic [3:0]  EXEC    = 4'b0010;
   localparam logic [5:0]  OP_BEQ  = 6'b000100;

   typedef struct packed {
      logic [31:0] pc;
      logic        ds;
      logic        act;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  state = 4'd0;
   logic        instr_done = 1'b0;
   logic        stall = 1'b0;
   logic        JumpIN = 1'b0;
   logic        Jump_EN = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic [5:0]  fn = 6'd0;
   logic [25:0] instr_index = 26'd0;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        delay_slot;
   logic        active;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   pc_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .state       (state),
      .instr_done  (instr_done),
      .stall       (stall),
      .JumpIN      (JumpIN),
      .Jump_EN     (Jump_EN),
      .opcode      (opcode),
      .fn          (fn),
      .instr_index (instr_index),
      .rs_data     (rs_data),
      .pc          (pc),
      .link_addr   (link_addr),
      .delay_slot  (delay_slot),
      .active      (active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock step: drive inputs, queue expectation, clock, pop and compare
   task automatic cyc(input logic r, input logic [3:0] st, input logic d, input logic s,
                      input logic [1:0] jj, input logic [5:0] op, input logic [5:0] f,
                      input logic [25:0] idx, input logic [31:0] rs,
                      input logic [31:0] epc, input logic eds, input logic eact,
                      input string tag);
      exp_t e;
      reset = r; state = st; instr_done = d; stall = s;
      JumpIN = jj[1]; Jump_EN = jj[0];
      opcode = op; fn = f; instr_index = idx; rs_data = rs;
      exp_q.push_back('{pc: epc, ds: eds, act: eact});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".pc"}, pc, e.pc);
      check({tag, ".ds"}, {31'd0, delay_slot}, {31'd0, e.ds});
      check({tag, ".act"}, {31'd0, active}, {31'd0, e.act});
   endtask

   initial begin
      // Reset (second cycle with stall high: reset must still win)
      cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, RV, 0, 1, "reset0");
      cyc(1, 0, 1, 1, 2'b11, 0, 0, 0, 0, RV, 0, 1, "reset1");
      // Sequential fetch
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_0004, 0, 1, "seq1");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_0008, 0, 1, "seq2");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_000C, 0, 1, "seq3");
      check("link_seq", link_addr, 32'hBFC0_0014);
      // Taken outside EXEC is not a branch
      cyc(0, 4'b0011, 1, 0, 2'b11, OP_BEQ, 0, 26'h000FFFC, 0, 32'hBFC0_0010, 0, 1, "wrong_state");
      // BEQ at BFC00010, backward branch, retires two cycles later
      cyc(0, EXEC, 0, 0, 2'b11, OP_BEQ, 0, 26'h000FFFC, 0, 32'hBFC0_0010, 0, 1, "beq_arm");
      cyc(0, 0, 0, 0, 2'b11, OP_BEQ, 0, 26'h000FFFC, 0, 32'hBFC0_0010, 0, 1, "armed_wait");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_0014, 1, 1, "beq_slot");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_0004, 0, 1, "beq_target");
      // JumpIN without Jump_EN is not a branch
      cyc(0, EXEC, 1, 0, 2'b10, OP_BEQ, 0, 26'h000FFFC, 0, 32'hBFC0_0008, 0, 1, "no_enable");
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_000C + 32'(i) * 32'd4, 0, 1, "walk");
      end
      check("link_j", link_addr, 32'hBFC0_0028);
      // J at BFC00020, taken and retired same cycle
      cyc(0, EXEC, 1, 0, 2'b11, OP_J, 0, 26'h0000100, 0, 32'hBFC0_0024, 1, 1, "j_slot");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hB000_0400, 0, 1, "j_target");
      // JR to 0; delay slot holds a taken JALR that must be dropped
      cyc(0, EXEC, 1, 0, 2'b11, OP_SPECIAL, FN_JR, 0, 32'h0, 32'hB000_0404, 1, 1, "jr_slot");
      cyc(0, EXEC, 0, 0, 2'b11, OP_SPECIAL, FN_JALR, 0, 32'h1234_5678, 32'hB000_0404, 1, 1, "slot_branch");
      cyc(0, EXEC, 1, 0, 2'b11, OP_SPECIAL, FN_JR, 0, 32'h1234_5678, 32'h0, 0, 1, "jr_zero");
      cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 0, 0, "halt");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0, 0, 0, "halt_done1");
      cyc(0, EXEC, 1, 0, 2'b11, OP_J, 0, 26'h0000100, 0, 32'h0, 0, 0, "halt_done2");
      // Only reset leaves halt
      cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, RV, 0, 1, "reset_halt");
      // Stall blocks retire and branch latch
      cyc(0, EXEC, 1, 1, 2'b11, OP_J, 0, 26'h0000100, 0, RV, 0, 1, "stall_frozen");
      cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, RV, 0, 1, "post_stall_idle");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_0004, 0, 1, "post_stall_done");
      // Reset while ARMED discards the pending target
      cyc(0, EXEC, 0, 0, 2'b11, OP_BEQ, 0, 26'h000FFFC, 0, 32'hBFC0_0004, 0, 1, "arm2");
      cyc(1, 0, 0, 1, 2'b00, 0, 0, 0, 0, RV, 0, 1, "reset_armed");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_0004, 0, 1, "after_reset_done");
      cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'hBFC0_0008, 0, 1, "after_reset_done2");
      check("sb_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pc_sequencer
`default_nettype wire
